// File: rtl/score_disp_pkg.sv
// Shared types and constants for the score BCD display: FSM states,
// active-low 7-segment patterns and the decimal saturation limit.
package score_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low gfedcba patterns for decimal digits 0..9
  localparam logic [6:0] SEG_LUT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic logic [63:0] sat_limit(input int digits);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < digits; i++) begin
      v = v * 64'd10;
    end
    return v - 64'd1;
  endfunction

endpackage

// File: rtl/hex_seg7.sv
// One BCD digit to an active-low 7-segment pattern; blank or non-decimal
// codes turn every segment off.
module hex_seg7
  import score_disp_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (bcd <= 4'd9)) begin
      seg = SEG_LUT[bcd];
    end
  end

endmodule

// File: rtl/score_bcd_display.sv
// Binary score to saturated BCD via a serial double-dabble engine, shown
// on active-low 7-segment displays that only change when a conversion commits.
module score_bcd_display
  import score_disp_pkg::*;
#(
  parameter int WIDTH         = 24,
  parameter int DIGITS        = 6,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      score,
  input  logic                  display_en,
  output logic [DIGITS*7-1:0]   hex,
  output logic                  overflow,
  output logic                  busy
);

  localparam logic [63:0] LIMIT = sat_limit(DIGITS);
  localparam int          BCD_W = DIGITS * 4;
  localparam int          CNT_W = $clog2(WIDTH + 1);

  state_t             state_reg;
  logic [WIDTH-1:0]   shown_reg;
  logic [WIDTH-1:0]   src_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic [BCD_W-1:0]   bcd_disp_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               ovf_pend_reg;

  logic [63:0]        score_ext;
  logic               over_limit;
  logic [WIDTH-1:0]   src_capture;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_shift;
  logic [WIDTH-1:0]   src_shift;
  logic [BCD_W-1:0]   hex_src;
  logic [DIGITS:0]    nz_from;
  logic [DIGITS-1:0]  blank;
  logic [DIGITS*7-1:0] hex_next;
  logic [DIGITS*7-1:0] rst_hex;

  assign score_ext   = 64'(score);
  assign over_limit  = score_ext > LIMIT;
  assign src_capture = over_limit ? LIMIT[WIDTH-1:0] : score;

  // Double-dabble step: add-3 correction on each nibble, then one shift
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 :
                                  bcd_reg[gi*4 +: 4];
    end
  endgenerate

  assign bcd_shift = {bcd_adj[BCD_W-2:0], src_reg[WIDTH-1]};
  assign src_shift = {src_reg[WIDTH-2:0], 1'b0};

  // On the commit edge the fresh result feeds the display directly, so hex
  // and overflow switch together on the same edge.
  assign hex_src = (state_reg == COMMIT) ? bcd_reg : bcd_disp_reg;

  assign nz_from[DIGITS] = 1'b0;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign nz_from[gi] = nz_from[gi+1] | (hex_src[gi*4 +: 4] != 4'd0);

      if (gi == 0) begin : g_ones
        assign blank[gi]          = !display_en;
        assign rst_hex[gi*7 +: 7] = display_en ? SEG_LUT[0] : SEG_BLANK;
      end else begin : g_upper
        assign blank[gi]          = !display_en || (BLANK_LEADING && !nz_from[gi]);
        assign rst_hex[gi*7 +: 7] = (display_en && !BLANK_LEADING) ?
                                    SEG_LUT[0] : SEG_BLANK;
      end

      hex_seg7 u_seg (
        .bcd   (hex_src[gi*4 +: 4]),
        .blank (blank[gi]),
        .seg   (hex_next[gi*7 +: 7])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      shown_reg    <= '0;
      src_reg      <= '0;
      bcd_reg      <= '0;
      bcd_disp_reg <= '0;
      count_reg    <= '0;
      ovf_pend_reg <= 1'b0;
      overflow     <= 1'b0;
      busy         <= 1'b0;
      hex          <= rst_hex;
    end else begin
      hex <= hex_next;
      case (state_reg)
        IDLE: begin
          if (score != shown_reg) begin
            src_reg      <= src_capture;
            ovf_pend_reg <= over_limit;
            shown_reg    <= score;
            bcd_reg      <= '0;
            count_reg    <= '0;
            busy         <= 1'b1;
            state_reg    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_reg   <= bcd_shift;
          src_reg   <= src_shift;
          count_reg <= count_reg + CNT_W'(1);
          if (count_reg == CNT_W'(WIDTH - 1)) begin
            state_reg <= COMMIT;
          end
        end
        COMMIT: begin
          bcd_disp_reg <= bcd_reg;
          overflow     <= ovf_pend_reg;
          busy         <= 1'b0;
          state_reg    <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_bcd_display.sv
// Randomized scoreboard bench: stimulus pushes expected commits, a monitor
// pops and compares them whenever a conversion finishes.
module tb_score_bcd_display;

  logic        clk;
  logic        rst;
  logic [23:0] score;
  logic        display_en;
  logic [41:0] hex;
  logic [41:0] hex_nb;
  logic        overflow;
  logic        overflow_nb;
  logic        busy;
  logic        busy_nb;

  int tests;
  int fails;
  int cyc;
  int unsigned last_score;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct {
    int unsigned value;
    logic [41:0] hex;
    logic [41:0] hex_nb;
    logic        ovf;
    int          at_cyc;
  } exp_t;

  exp_t exp_q[$];

  score_bcd_display #(.WIDTH(24), .DIGITS(6), .BLANK_LEADING(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .score      (score),
    .display_en (display_en),
    .hex        (hex),
    .overflow   (overflow),
    .busy       (busy)
  );

  score_bcd_display #(.WIDTH(24), .DIGITS(6), .BLANK_LEADING(1'b0)) dut_nb (
    .clk        (clk),
    .rst        (rst),
    .score      (score),
    .display_en (display_en),
    .hex        (hex_nb),
    .overflow   (overflow_nb),
    .busy       (busy_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Decimal digit i is blanked when the saturated value has fewer than i+1 digits
  function automatic logic [41:0] ref_hex(input int unsigned v, input bit en, input bit bl);
    int unsigned s;
    int unsigned p;
    int unsigned d;
    logic [41:0] r;
    s = (v > 999999) ? 999999 : v;
    p = 1;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      d = (s / p) % 10;
      if (!en || (bl && i > 0 && s < p)) r[i*7 +: 7] = 7'h7F;
      else                               r[i*7 +: 7] = seg_tab[d];
      p = p * 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int unsigned v, input int at_cyc);
    exp_t e;
    e.value  = v;
    e.hex    = ref_hex(v, display_en, 1'b1);
    e.hex_nb = ref_hex(v, display_en, 1'b0);
    e.ovf    = (v > 999999);
    e.at_cyc = at_cyc;
    exp_q.push_back(e);
  endtask

  // Called just after a posedge: sampled on the next edge, committed 25 later
  task automatic start(input int unsigned v);
    score      = v[23:0];
    last_score = v;
    push_exp(v, cyc + 26);
  endtask

  task automatic conv(input int unsigned v);
    bit done;
    start(v);
    @(negedge clk);
    check("busy_before_sample", 64'(busy), 64'd0);
    @(negedge clk);
    check("busy_rise", 64'(busy), 64'd1);
    done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    check("conversion_done", 64'(done), 64'd1);
    tick();
  endtask

  // Monitor: a busy fall outside reset is a commit
  initial begin
    logic prev_busy;
    exp_t e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 1'b0;
      end else begin
        if (prev_busy && !busy) begin
          if (exp_q.size() == 0) begin
            check("unexpected_commit", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            $display("[TB] commit score=%0d en=%0b hex=%h ovf=%0b cyc=%0d",
                     e.value, display_en, hex, overflow, cyc);
            check("commit_cycle", 64'(cyc), 64'(e.at_cyc));
            check("commit_hex", 64'(hex), 64'(e.hex));
            check("commit_hex_noblank", 64'(hex_nb), 64'(e.hex_nb));
            check("commit_overflow", 64'(overflow), 64'(e.ovf));
            check("commit_overflow_noblank", 64'(overflow_nb), 64'(e.ovf));
          end
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned v;
    bit seen_busy;
    int n;

    tests      = 0;
    fails      = 0;
    last_score = 0;
    rst        = 1'b1;
    score      = '0;
    display_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hex", 64'(hex), 64'(ref_hex(0, 1'b1, 1'b1)));
    check("reset_hex_noblank", 64'(hex_nb), 64'(ref_hex(0, 1'b1, 1'b0)));
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;

    seen_busy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy) seen_busy = 1'b1;
    end
    check("no_busy_after_reset", 64'(seen_busy), 64'd0);
    check("idle_hex_zero", 64'(hex), 64'(ref_hex(0, 1'b1, 1'b1)));

    conv(123456);
    conv(5);
    conv(1000000);
    conv(7);

    // display_en gating: commit blanked, then enable shows after one edge
    display_en = 1'b0;
    conv(31);
    display_en = 1'b1;
    check("en_hold_before_edge", 64'(hex), 64'(ref_hex(31, 1'b0, 1'b1)));
    tick();
    check("en_on_hex", 64'(hex), 64'(ref_hex(31, 1'b1, 1'b1)));
    check("en_on_hex0", 64'(hex[6:0]), 64'(7'h79));
    display_en = 1'b0;
    tick();
    check("en_off_idle", 64'(hex), 64'(ref_hex(31, 1'b0, 1'b1)));
    display_en = 1'b1;
    tick();

    // Score change mid-conversion: first value commits, second follows
    start(42);
    n = cyc;
    repeat (10) tick();
    score      = 24'd987654;
    last_score = 987654;
    push_exp(987654, n + 52);
    repeat (60) tick();
    check("midchange_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-SHIFT discards the partial result
    score = 24'd654321;
    repeat (9) tick();
    rst = 1'b1;
    #1;
    check("midreset_hex", 64'(hex), 64'(ref_hex(0, 1'b1, 1'b1)));
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_overflow", 64'(overflow), 64'd0);
    repeat (2) tick();
    rst = 1'b0;
    start(654321);
    repeat (40) tick();
    check("midreset_drained", 64'(exp_q.size()), 64'd0);

    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 99);
        1:       v = $urandom_range(0, 999999);
        2:       v = $urandom_range(999990, 1000010);
        default: v = $urandom & 32'h00FF_FFFF;
      endcase
      if (v == last_score) v = (v == 0) ? 1 : v - 1;
      display_en = ($urandom_range(0, 3) != 0);
      conv(v);
    end

    repeat (5) tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
